// File: rtl/bit_scan8_if.sv
// Handshake bundle for bit_scan8: vector input stream and index output stream.
// The master drives vectors and consumes beats; the slave is the scanner.
interface bit_scan8_if;
   logic [7:0] in_vector;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] out_index;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       out_empty;
   logic [3:0] out_count;

   modport master (
      output in_vector, in_valid, out_ready,
      input  in_ready, out_index, out_valid, out_last, out_empty, out_count
   );

   modport slave (
      input  in_vector, in_valid, out_ready,
      output in_ready, out_index, out_valid, out_last, out_empty, out_count
   );
endinterface

// File: rtl/bit_scan8.sv
// Expands a captured 8-bit vector into its set-bit indices, LSB first, one per beat.
// An all-zero vector produces a single beat flagged empty.
module bit_scan8 (
   input  logic        clk,
   input  logic        rst_n,
   bit_scan8_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] pending;
   logic [3:0] count_q;
   logic       empty_q;
   logic       alive_q;
   logic       in_ready_w;
   logic       out_valid_w;
   logic       out_last_w;
   logic       in_fire;
   logic       out_fire;
   logic [2:0] low_idx;
   logic       single;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   assign in_ready_w  = alive_q && (state == IDLE);
   assign out_valid_w = (state == SCAN);
   assign in_fire     = bus.in_valid && in_ready_w;
   assign out_fire    = out_valid_w && bus.out_ready;

   // Priority encoder: highest index assigned first so the lowest set bit wins.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pending[i]) begin
            low_idx = 3'(i);
         end
      end
   end

   assign single     = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);
   assign out_last_w = out_valid_w && (empty_q || single);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_fire) state_nxt = SCAN;
         SCAN: if (out_fire && out_last_w) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Holds in_ready low during reset and for the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: pending is reset along with state so an abandoned vector never resumes.
         pending <= 8'd0;
         count_q <= 4'd0;
         empty_q <= 1'b0;
      end else if (in_fire) begin
         pending <= bus.in_vector;
         count_q <= popcount8(bus.in_vector);
         empty_q <= (bus.in_vector == 8'd0);
      end else if (out_fire) begin
         pending <= pending & (pending - 8'd1);
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.out_index = (out_valid_w && !empty_q) ? low_idx : 3'd0;
   assign bus.out_last  = out_last_w;
   assign bus.out_empty = out_valid_w && empty_q;
   assign bus.out_count = count_q;

endmodule

// File: tb/tb_bit_scan8.sv
// Directed and randomized checks of bit_scan8 against a list-of-indices reference model.
module tb_bit_scan8;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   bit_scan8_if bus ();

   bit_scan8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sends one vector from IDLE (at a negedge) and drains it; ends at the negedge after the
   // last beat. stall = initial cycles with out_ready low, pct = later out_ready probability.
   task automatic send(input logic [7:0] v, input int pct, input int stall);
      int  exp_idx[$];
      int  k;
      int  cyc;
      int  n;
      bit  empty;
      logic [3:0] cnt;

      for (int i = 0; i < 8; i++) if (v[i]) exp_idx.push_back(i);
      empty = (exp_idx.size() == 0);
      if (empty) exp_idx.push_back(0);
      n   = exp_idx.size();
      cnt = 4'($countones(v));

      check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
      bus.in_vector = v;
      bus.in_valid  = 1'b1;
      @(negedge clk);

      k   = 0;
      cyc = 0;
      while (k < n && cyc < 200) begin
         // Offer a competing vector throughout the scan; it must be ignored.
         bus.in_valid  = 1'b1;
         bus.in_vector = 8'($urandom);
         check("scan_valid", {31'd0, bus.out_valid}, 32'd1);
         check("scan_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("index", {29'd0, bus.out_index}, exp_idx[k]);
         check("last", {31'd0, bus.out_last}, {31'd0, (k == n - 1)});
         check("empty", {31'd0, bus.out_empty}, {31'd0, empty});
         check("count", {28'd0, bus.out_count}, {28'd0, cnt});
         if (cyc < stall) bus.out_ready = 1'b0;
         else             bus.out_ready = ($urandom_range(0, 99) < pct);
         if (bus.out_ready) k++;
         cyc++;
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'($urandom);
      check("drain_in_time", {31'd0, (k == n)}, 32'd1);
      if (pct >= 100 && stall == 0) check("throughput", cyc, n);
      check("done_valid", {31'd0, bus.out_valid}, 32'd0);
      check("done_in_ready", {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_vector = 8'd0;
      bus.out_ready = 1'b0;

      #1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_index", {29'd0, bus.out_index}, 32'd0);
      check("rst_last", {31'd0, bus.out_last}, 32'd0);
      check("rst_empty", {31'd0, bus.out_empty}, 32'd0);
      check("rst_count", {28'd0, bus.out_count}, 32'd0);

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      check("release_in_ready_high", {31'd0, bus.in_ready}, 32'd1);

      send(8'hA5, 100, 0);
      send(8'h00, 100, 0);
      send(8'h80, 100, 0);
      send(8'h06, 100, 3);

      // Reset in the middle of a scan of 0xFF after three beats.
      bus.in_vector = 8'hFF;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         check("ff_index", {29'd0, bus.out_index}, b);
         @(negedge clk);
      end
      check("ff_still_valid", {31'd0, bus.out_valid}, 32'd1);
      check("ff_index3", {29'd0, bus.out_index}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("midrst_count", {28'd0, bus.out_count}, 32'd0);
      check("midrst_index", {29'd0, bus.out_index}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      send(8'h01, 100, 0);

      // Back-to-back random vectors with random back-pressure.
      for (int t = 0; t < 40; t++) begin
         logic [7:0] v;
         case ($urandom_range(0, 9))
            0:       v = 8'h00;
            1:       v = 8'hFF;
            default: v = 8'($urandom);
         endcase
         send(v, int'($urandom_range(30, 100)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
